// File: rtl/axi_errslave.sv
// AXI4 error slave: terminates every read/write burst with DECERR/SLVERR,
// queues outstanding bursts per direction, and keeps error counters and last addresses.
module axi_errslave #(
  parameter int unsigned                  C_AXI_ID_WIDTH   = 2,
  parameter int unsigned                  C_AXI_DATA_WIDTH = 32,
  parameter int unsigned                  C_AXI_ADDR_WIDTH = 6,
  parameter int unsigned                  LGFIFO           = 2,
  parameter logic                         OPT_SLVERR       = 1'b0,
  parameter logic [C_AXI_DATA_WIDTH-1:0]  RDATA_FILL       = '0,
  parameter int unsigned                  LGCNT            = 16
) (
  input  logic                         S_AXI_ACLK,
  input  logic                         S_AXI_ARESETN,
  input  logic                         S_AXI_AWVALID,
  output logic                         S_AXI_AWREADY,
  input  logic [C_AXI_ID_WIDTH-1:0]    S_AXI_AWID,
  input  logic [C_AXI_ADDR_WIDTH-1:0]  S_AXI_AWADDR,
  input  logic                         S_AXI_WVALID,
  output logic                         S_AXI_WREADY,
  input  logic                         S_AXI_WLAST,
  output logic                         S_AXI_BVALID,
  input  logic                         S_AXI_BREADY,
  output logic [C_AXI_ID_WIDTH-1:0]    S_AXI_BID,
  output logic [1:0]                   S_AXI_BRESP,
  input  logic                         S_AXI_ARVALID,
  output logic                         S_AXI_ARREADY,
  input  logic [C_AXI_ID_WIDTH-1:0]    S_AXI_ARID,
  input  logic [C_AXI_ADDR_WIDTH-1:0]  S_AXI_ARADDR,
  input  logic [7:0]                   S_AXI_ARLEN,
  output logic                         S_AXI_RVALID,
  input  logic                         S_AXI_RREADY,
  output logic [C_AXI_ID_WIDTH-1:0]    S_AXI_RID,
  output logic [C_AXI_DATA_WIDTH-1:0]  S_AXI_RDATA,
  output logic                         S_AXI_RLAST,
  output logic [1:0]                   S_AXI_RRESP,
  input  logic                         i_clear,
  output logic [LGCNT-1:0]             o_werr_count,
  output logic [LGCNT-1:0]             o_rerr_count,
  output logic [C_AXI_ADDR_WIDTH-1:0]  o_last_awaddr,
  output logic [C_AXI_ADDR_WIDTH-1:0]  o_last_araddr
);

  localparam int unsigned DEPTH = 1 << LGFIFO;
  localparam logic [1:0]  RESP  = OPT_SLVERR ? 2'b10 : 2'b11;
  localparam logic [0:0]  S_IDLE  = 1'b0;
  localparam logic [0:0]  S_BURST = 1'b1;

  // ---------------- write side ----------------
  logic [C_AXI_ID_WIDTH-1:0] aw_mem [DEPTH];
  logic [LGFIFO-1:0]         aw_wr, aw_rd;
  logic [LGFIFO:0]           aw_cnt;
  logic                      aw_full, aw_empty, aw_push, aw_pop;

  // Count MSB is set only when the queue holds exactly DEPTH entries.
  assign aw_full  = aw_cnt[LGFIFO];
  assign aw_empty = (aw_cnt == '0);
  assign aw_push  = S_AXI_AWVALID && !aw_full;
  assign S_AXI_AWREADY = !aw_full;
  assign S_AXI_WREADY  = !S_AXI_WLAST || (!aw_empty && (!S_AXI_BVALID || S_AXI_BREADY));
  assign aw_pop   = S_AXI_WVALID && S_AXI_WLAST && S_AXI_WREADY;
  assign S_AXI_BRESP = RESP;

  always_ff @(posedge S_AXI_ACLK) begin
    if (aw_push) aw_mem[aw_wr] <= S_AXI_AWID;
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      aw_wr         <= '0;
      aw_rd         <= '0;
      aw_cnt        <= '0;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_BID     <= '0;
      o_last_awaddr <= '0;
    end else begin
      if (aw_push) begin
        aw_wr         <= aw_wr + LGFIFO'(1);
        o_last_awaddr <= S_AXI_AWADDR;
      end
      if (aw_pop) aw_rd <= aw_rd + LGFIFO'(1);
      case ({aw_push, aw_pop})
        2'b10:   aw_cnt <= aw_cnt + (LGFIFO+1)'(1);
        2'b01:   aw_cnt <= aw_cnt - (LGFIFO+1)'(1);
        default: ;
      endcase
      if (aw_pop) begin
        S_AXI_BVALID <= 1'b1;
        S_AXI_BID    <= aw_mem[aw_rd];
      end else if (S_AXI_BREADY) begin
        S_AXI_BVALID <= 1'b0;
      end
    end
  end

  // ---------------- read side ----------------
  logic [C_AXI_ID_WIDTH-1:0] ar_id_mem  [DEPTH];
  logic [7:0]                ar_len_mem [DEPTH];
  logic [LGFIFO-1:0]         ar_wr, ar_rd;
  logic [LGFIFO:0]           ar_cnt;
  logic                      ar_full, ar_empty, ar_push, ar_pop;
  logic [0:0]                state;
  logic [7:0]                beats;
  logic                      r_hs, r_last_hs;

  assign ar_full  = ar_cnt[LGFIFO];
  assign ar_empty = (ar_cnt == '0);
  assign ar_push  = S_AXI_ARVALID && !ar_full;
  assign S_AXI_ARREADY = !ar_full;

  assign S_AXI_RVALID = (state == S_BURST);
  assign S_AXI_RLAST  = (state == S_BURST) && (beats == 8'd0);
  assign S_AXI_RDATA  = RDATA_FILL;
  assign S_AXI_RRESP  = RESP;
  assign r_hs      = S_AXI_RVALID && S_AXI_RREADY;
  assign r_last_hs = r_hs && S_AXI_RLAST;
  // Reloading on the last-beat handshake keeps queued bursts streaming without a bubble.
  assign ar_pop    = !ar_empty && ((state == S_IDLE) || r_last_hs);

  always_ff @(posedge S_AXI_ACLK) begin
    if (ar_push) begin
      ar_id_mem[ar_wr]  <= S_AXI_ARID;
      ar_len_mem[ar_wr] <= S_AXI_ARLEN;
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      ar_wr         <= '0;
      ar_rd         <= '0;
      ar_cnt        <= '0;
      state         <= S_IDLE;
      beats         <= '0;
      S_AXI_RID     <= '0;
      o_last_araddr <= '0;
    end else begin
      if (ar_push) begin
        ar_wr         <= ar_wr + LGFIFO'(1);
        o_last_araddr <= S_AXI_ARADDR;
      end
      if (ar_pop) ar_rd <= ar_rd + LGFIFO'(1);
      case ({ar_push, ar_pop})
        2'b10:   ar_cnt <= ar_cnt + (LGFIFO+1)'(1);
        2'b01:   ar_cnt <= ar_cnt - (LGFIFO+1)'(1);
        default: ;
      endcase
      if (ar_pop) begin
        state     <= S_BURST;
        beats     <= ar_len_mem[ar_rd];
        S_AXI_RID <= ar_id_mem[ar_rd];
      end else if (r_last_hs) begin
        state <= S_IDLE;
      end else if (r_hs) begin
        beats <= beats - 8'd1;
      end
    end
  end

  // ---------------- error counters ----------------
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      o_werr_count <= '0;
      o_rerr_count <= '0;
    end else begin
      if (i_clear)
        o_werr_count <= '0;
      else if (S_AXI_BVALID && S_AXI_BREADY && (o_werr_count != '1))
        o_werr_count <= o_werr_count + LGCNT'(1);
      if (i_clear)
        o_rerr_count <= '0;
      else if (r_last_hs && (o_rerr_count != '1))
        o_rerr_count <= o_rerr_count + LGCNT'(1);
    end
  end

endmodule

// File: tb/tb_axi_errslave.sv
// Self-checking bench for axi_errslave: directed scenarios plus random traffic
// checked every cycle against a queue-based transaction model.
module tb_axi_errslave;

  localparam int IW = 2;
  localparam int DW = 32;
  localparam int AW = 6;
  localparam logic [DW-1:0] FILL = 32'hC0DE_F00D;

  logic clk, rst_n;
  logic awvalid, wvalid, wlast, bready, arvalid, rready, clr;
  logic [IW-1:0] awid, arid;
  logic [AW-1:0] awaddr, araddr;
  logic [7:0]    arlen;

  logic awready, wready, bvalid, arready, rvalid, rlast;
  logic [IW-1:0] bid, rid;
  logic [1:0] bresp, rresp;
  logic [DW-1:0] rdata;
  logic [15:0] werr, rerr;
  logic [AW-1:0] law, lar;

  logic awready2, wready2, bvalid2, arready2, rvalid2, rlast2;
  logic [IW-1:0] bid2, rid2;
  logic [1:0] bresp2, rresp2;
  logic [DW-1:0] rdata2;
  logic [1:0] werr2, rerr2;
  logic [AW-1:0] law2, lar2;

  int checks = 0;
  int errors = 0;

  axi_errslave #(.C_AXI_ID_WIDTH(IW), .C_AXI_DATA_WIDTH(DW), .C_AXI_ADDR_WIDTH(AW),
    .LGFIFO(2), .OPT_SLVERR(1'b0), .RDATA_FILL(FILL), .LGCNT(16)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready), .S_AXI_AWID(awid), .S_AXI_AWADDR(awaddr),
    .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready), .S_AXI_WLAST(wlast),
    .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready), .S_AXI_BID(bid), .S_AXI_BRESP(bresp),
    .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready), .S_AXI_ARID(arid), .S_AXI_ARADDR(araddr),
    .S_AXI_ARLEN(arlen),
    .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready), .S_AXI_RID(rid), .S_AXI_RDATA(rdata),
    .S_AXI_RLAST(rlast), .S_AXI_RRESP(rresp),
    .i_clear(clr), .o_werr_count(werr), .o_rerr_count(rerr),
    .o_last_awaddr(law), .o_last_araddr(lar));

  axi_errslave #(.C_AXI_ID_WIDTH(IW), .C_AXI_DATA_WIDTH(DW), .C_AXI_ADDR_WIDTH(AW),
    .LGFIFO(2), .OPT_SLVERR(1'b1), .RDATA_FILL(FILL), .LGCNT(2)) dut2 (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready2), .S_AXI_AWID(awid), .S_AXI_AWADDR(awaddr),
    .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready2), .S_AXI_WLAST(wlast),
    .S_AXI_BVALID(bvalid2), .S_AXI_BREADY(bready), .S_AXI_BID(bid2), .S_AXI_BRESP(bresp2),
    .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready2), .S_AXI_ARID(arid), .S_AXI_ARADDR(araddr),
    .S_AXI_ARLEN(arlen),
    .S_AXI_RVALID(rvalid2), .S_AXI_RREADY(rready), .S_AXI_RID(rid2), .S_AXI_RDATA(rdata2),
    .S_AXI_RLAST(rlast2), .S_AXI_RRESP(rresp2),
    .i_clear(clr), .o_werr_count(werr2), .o_rerr_count(rerr2),
    .o_last_awaddr(law2), .o_last_araddr(lar2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { logic [IW-1:0] id; logic [7:0] len; } ar_t;
  logic [IW-1:0] awq[$];
  ar_t           arq[$];
  logic          m_bv, m_ract;
  logic [IW-1:0] m_bid, m_rid;
  int            m_rleft, m_werr, m_rerr;
  logic [AW-1:0] m_law, m_lar;

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    awq.delete(); arq.delete();
    m_bv = 0; m_ract = 0; m_bid = '0; m_rid = '0; m_rleft = 0;
    m_werr = 0; m_rerr = 0; m_law = '0; m_lar = '0;
  endtask

  task automatic model_step();
    bit aw_rdy, ar_rdy, w_rdy, b_hs, r_hs, r_end, w_end;
    logic [IW-1:0] popped;
    ar_t h;
    aw_rdy = awq.size() < 4;
    ar_rdy = arq.size() < 4;
    w_rdy  = !wlast || (awq.size() != 0 && (!m_bv || bready));
    b_hs   = m_bv && bready;
    r_hs   = m_ract && rready;
    r_end  = r_hs && (m_rleft == 0);
    w_end  = wvalid && wlast && w_rdy;
    popped = '0;
    if (w_end) popped = awq.pop_front();
    if (awvalid && aw_rdy) begin awq.push_back(awid); m_law = awaddr; end
    if (w_end) begin m_bv = 1; m_bid = popped; end
    else if (bready) m_bv = 0;
    if (clr) m_werr = 0; else if (b_hs) m_werr++;
    if (clr) m_rerr = 0; else if (r_end) m_rerr++;
    if ((!m_ract || r_end) && arq.size() != 0) begin
      h = arq.pop_front();
      m_ract = 1; m_rid = h.id; m_rleft = int'(h.len);
    end else if (r_end) m_ract = 0;
    else if (r_hs) m_rleft--;
    if (arvalid && ar_rdy) begin arq.push_back('{arid, arlen}); m_lar = araddr; end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // Compare process: outputs are checked at every falling edge out of reset.
  initial begin
    bit ew;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        ew = !wlast || (awq.size() != 0 && (!m_bv || bready));
        chk("awready", awready, awq.size() < 4);
        chk("arready", arready, arq.size() < 4);
        chk("wready", wready, ew);
        chk("bvalid", bvalid, m_bv);
        chk("rvalid", rvalid, m_ract);
        chk("awready2", awready2, awq.size() < 4);
        chk("arready2", arready2, arq.size() < 4);
        chk("wready2", wready2, ew);
        chk("bvalid2", bvalid2, m_bv);
        chk("rvalid2", rvalid2, m_ract);
        if (m_bv) begin
          chk("bid", bid, m_bid);   chk("bresp", bresp, 2'b11);
          chk("bid2", bid2, m_bid); chk("bresp2", bresp2, 2'b10);
        end
        if (m_ract) begin
          chk("rid", rid, m_rid);   chk("rlast", rlast, m_rleft == 0);
          chk("rdata", rdata, FILL); chk("rresp", rresp, 2'b11);
          chk("rid2", rid2, m_rid); chk("rlast2", rlast2, m_rleft == 0);
          chk("rdata2", rdata2, FILL); chk("rresp2", rresp2, 2'b10);
        end
        chk("werr", werr, sat(m_werr, 65535));
        chk("rerr", rerr, sat(m_rerr, 65535));
        chk("werr2", werr2, sat(m_werr, 3));
        chk("rerr2", rerr2, sat(m_rerr, 3));
        chk("last_aw", law, m_law);  chk("last_ar", lar, m_lar);
        chk("last_aw2", law2, m_law); chk("last_ar2", lar2, m_lar);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    awvalid = 0; awid = '0; awaddr = '0; wvalid = 0; wlast = 0; bready = 1;
    arvalid = 0; arid = '0; araddr = '0; arlen = '0; rready = 1; clr = 0;
  endtask

  initial begin
    logic [IW-1:0] exp_ids[$];
    logic [IW-1:0] got_ids[$];
    rst_n = 0;
    idle();
    repeat (3) cyc();
    rst_n = 1;
    #1;
    chk("rst_awready", awready, 1); chk("rst_arready", arready, 1);
    chk("rst_bvalid", bvalid, 0);   chk("rst_rvalid", rvalid, 0);
    chk("rst_werr", werr, 0);       chk("rst_rerr", rerr, 0);
    cyc();

    // Single read: ARID=2, ARLEN=3
    arvalid = 1; arid = 2; arlen = 3; araddr = 6'h2A;
    cyc();
    arvalid = 0;
    chk("rd_lat1", rvalid, 0);
    cyc();
    for (int b = 1; b <= 4; b++) begin
      chk("rd_valid", rvalid, 1); chk("rd_id", rid, 2);
      chk("rd_last", rlast, b == 4); chk("rd_data", rdata, FILL); chk("rd_resp", rresp, 2'b11);
      cyc();
    end
    chk("rd_done", rvalid, 0); chk("rd_cnt", rerr, 1); chk("rd_addr", lar, 6'h2A);

    // Queue fill behind a stalled 16-beat burst, then stream without bubbles
    arvalid = 1; arid = 1; arlen = 15; araddr = 6'h01; rready = 0;
    cyc();
    arvalid = 0;
    cyc(); cyc();
    for (int i = 0; i < 4; i++) begin
      arvalid = 1; arid = IW'(i); arlen = 8'(i); araddr = AW'(i + 8);
      #1; chk("q_accept", arready, 1);
      cyc();
    end
    arid = 0; arlen = 0;
    chk("q_full", arready, 0);
    cyc();
    chk("q_full_hold", arready, 0);
    arvalid = 0; rready = 1;
    for (int k = 0; k < 16; k++) exp_ids.push_back(1);
    for (int i = 0; i < 4; i++) for (int k = 0; k <= i; k++) exp_ids.push_back(IW'(i));
    foreach (exp_ids[k]) begin
      chk("stream_valid", rvalid, 1); chk("stream_id", rid, exp_ids[k]);
      cyc();
    end
    chk("stream_end", rvalid, 0); chk("stream_cnt", rerr, 6); chk("stream_cnt2", rerr2, 3);

    // W beats ahead of their AW
    wvalid = 1; wlast = 0;
    for (int b = 0; b < 3; b++) begin
      #1; chk("w_early", wready, 1);
      cyc();
    end
    wlast = 1; awvalid = 1; awid = 1; awaddr = 6'h15;
    #1; chk("wlast_hold", wready, 0);
    cyc();
    awvalid = 0;
    #1; chk("wlast_go", wready, 1);
    cyc();
    wvalid = 0; wlast = 0;
    chk("b_valid", bvalid, 1); chk("b_id", bid, 1); chk("b_resp", bresp, 2'b11);
    chk("b_resp2", bresp2, 2'b10); chk("b_addr", law, 6'h15);
    cyc();
    chk("b_done", bvalid, 0); chk("b_cnt", werr, 1);

    // BREADY low with three writes queued
    bready = 0; wvalid = 1; wlast = 1; awvalid = 1;
    awid = 2; awaddr = 6'h20; cyc();
    awid = 0; awaddr = 6'h21; cyc();
    awid = 3; awaddr = 6'h22; cyc();
    awvalid = 0;
    for (int k = 0; k < 3; k++) begin
      chk("bhold_valid", bvalid, 1); chk("bhold_id", bid, 2); chk("bhold_wready", wready, 0);
      cyc();
    end
    bready = 1;
    #1;
    for (int k = 0; k < 10; k++) begin
      if (bvalid && bready) got_ids.push_back(bid);
      cyc();
    end
    wvalid = 0; wlast = 0;
    chk("b_order_n", got_ids.size(), 3);
    if (got_ids.size() == 3) begin
      chk("b_order0", got_ids[0], 2); chk("b_order1", got_ids[1], 0); chk("b_order2", got_ids[2], 3);
    end
    chk("wcnt", werr, 4); chk("wcnt_sat", werr2, 3);

    // Clear coinciding with a B handshake
    awvalid = 1; awid = 2; awaddr = 6'h3C; cyc();
    awvalid = 0; wvalid = 1; wlast = 1; cyc();
    wvalid = 0; wlast = 0; clr = 1;
    chk("clr_bvalid", bvalid, 1);
    cyc();
    clr = 0;
    chk("clr_werr", werr, 0); chk("clr_werr2", werr2, 0); chk("clr_rerr", rerr, 0);

    // Asynchronous reset in the middle of an 8-beat burst
    arvalid = 1; arid = 1; arlen = 7; araddr = 6'h11; cyc();
    arvalid = 0; cyc();
    cyc(); cyc();
    chk("mid_beat3", rvalid, 1);
    rst_n = 0;
    #1;
    chk("mid_rvalid", rvalid, 0); chk("mid_rlast", rlast, 0); chk("mid_bvalid", bvalid, 0);
    chk("mid_lastar", lar, 0);
    cyc(); cyc();
    rst_n = 1;
    repeat (3) cyc();
    chk("post_rvalid", rvalid, 0); chk("post_arready", arready, 1);

    // Random traffic
    for (int ph = 0; ph < 15; ph++) begin
      int unsigned bp, rp;
      bp = $urandom_range(10, 100);
      rp = $urandom_range(10, 100);
      for (int c = 0; c < 200; c++) begin
        awvalid = ($urandom_range(0, 99) < 40);
        awid    = IW'($urandom);
        awaddr  = AW'($urandom);
        wvalid  = ($urandom_range(0, 99) < 60);
        wlast   = ($urandom_range(0, 3) == 0);
        bready  = ($urandom_range(1, 100) <= bp);
        arvalid = ($urandom_range(0, 99) < 35);
        arid    = IW'($urandom);
        araddr  = AW'($urandom);
        arlen   = 8'($urandom_range(0, 7));
        rready  = ($urandom_range(1, 100) <= rp);
        clr     = ($urandom_range(0, 199) == 0);
        cyc();
      end
    end
    idle();
    repeat (40) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
